// File: rtl/dmac_iochannel_burst_sequencer.sv
// AXI burst master for the DMA I/O channel: splits one word-count command into
// boundary-safe bursts and moves the data between a word stream and the bus.
module dmac_iochannel_burst_sequencer #(
  parameter int W_D           = 32,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = 12,
  parameter int W_BLEN        = 8,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [W_EXT_A-1:0] cmd_addr,
  input  logic [W_SIZE-1:0]  cmd_size,
  output logic               done,
  output logic               err,
  input  logic [W_D-1:0]     wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [W_D-1:0]     rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               awvalid,
  output logic [W_EXT_A-1:0] awaddr,
  output logic [W_BLEN-1:0]  awlen,
  input  logic               awready,
  output logic               wvalid,
  output logic [W_D-1:0]     wdata,
  output logic               wlast,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  output logic [W_EXT_A-1:0] araddr,
  output logic [W_BLEN-1:0]  arlen,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [W_D-1:0]     rdata,
  input  logic               rlast,
  output logic               rready
);

  localparam int WB_SHIFT = $clog2(W_D / 8);
  localparam logic [W_SIZE:0] ONE         = {{W_SIZE{1'b0}}, 1'b1};
  localparam logic [W_SIZE:0] MAX_LEN     = (W_SIZE + 1)'(MAX_BURST_LEN);
  localparam logic [W_SIZE:0] BOUND_BYTES = ONE << W_BOUNDARY_A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [W_EXT_A-1:0]   addr_r, addr_s, end_addr_s;
  logic [W_SIZE-1:0]    rem_r, rem_s, end_rem_s;
  logic [W_SIZE:0]      beats_r, beats_s, cnt_r, cnt_s;
  logic                 write_r, write_s, err_r, err_s, done_r, done_s;
  logic                 cmd_ready_r, awvalid_r, arvalid_r, bready_r;
  logic                 last_beat_s, finish_s;

  // Beats that fit before the boundary, capped by the burst limit and the words left.
  function automatic logic [W_SIZE:0] burst_beats(input logic [W_BOUNDARY_A-1:0] addr_lo,
                                                  input logic [W_SIZE-1:0]       rem);
    logic [W_SIZE:0] room;
    logic [W_SIZE:0] beats;
    room  = (BOUND_BYTES - {{(W_SIZE + 1 - W_BOUNDARY_A){1'b0}}, addr_lo}) >> WB_SHIFT;
    beats = {1'b0, rem};
    beats = (beats > MAX_LEN) ? MAX_LEN : beats;
    beats = (beats > room) ? room : beats;
    return beats;
  endfunction

  assign last_beat_s = (cnt_r == beats_r - ONE);
  assign end_addr_s  = addr_r + W_EXT_A'(beats_r << WB_SHIFT);
  assign end_rem_s   = rem_r - W_SIZE'(beats_r);

  // Next-state, burst bookkeeping and error/done generation.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    rem_s    = rem_r;
    write_s  = write_r;
    beats_s  = beats_r;
    cnt_s    = cnt_r;
    err_s    = err_r;
    done_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          addr_s  = cmd_addr;
          rem_s   = cmd_size;
          write_s = cmd_write;
          err_s   = 1'b0;
          cnt_s   = {(W_SIZE + 1){1'b0}};
          beats_s = burst_beats(cmd_addr[W_BOUNDARY_A-1:0], cmd_size);
          if (cmd_size == {W_SIZE{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_ADDR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if ((awvalid_r && awready) || (arvalid_r && arready)) begin
          state_s = write_r ? ST_WDATA : ST_RDATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (wr_valid && wready) begin
          if (last_beat_s) begin
            cnt_s   = {(W_SIZE + 1){1'b0}};
            state_s = ST_WRESP;
          end else begin
            cnt_s = cnt_r + ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_WRESP: begin
        finish_s = bvalid && bready_r;
      end
      ST_RDATA: begin
        if (rvalid && rd_ready) begin
          // rlast must coincide exactly with the computed final beat.
          err_s = err_r | (rlast != last_beat_s);
          if (last_beat_s) begin
            finish_s = 1'b1;
          end else begin
            cnt_s = cnt_r + ONE;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    if (finish_s) begin
      addr_s  = end_addr_s;
      rem_s   = end_rem_s;
      cnt_s   = {(W_SIZE + 1){1'b0}};
      beats_s = burst_beats(end_addr_s[W_BOUNDARY_A-1:0], end_rem_s);
      if (end_rem_s == {W_SIZE{1'b0}}) begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end else begin
        state_s = ST_ADDR;
      end
    end else begin
      done_s = done_s;
    end
  end

  // State and registered handshake outputs with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r     <= ST_IDLE;
      addr_r      <= {W_EXT_A{1'b0}};
      rem_r       <= {W_SIZE{1'b0}};
      beats_r     <= {(W_SIZE + 1){1'b0}};
      cnt_r       <= {(W_SIZE + 1){1'b0}};
      write_r     <= 1'b0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      arvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      rem_r       <= rem_s;
      beats_r     <= beats_s;
      cnt_r       <= cnt_s;
      write_r     <= write_s;
      err_r       <= err_s;
      done_r      <= done_s;
      cmd_ready_r <= (state_s == ST_IDLE) && !done_s;
      awvalid_r   <= (state_s == ST_ADDR) && write_s;
      arvalid_r   <= (state_s == ST_ADDR) && !write_s;
      bready_r    <= (state_s == ST_WRESP);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign done      = done_r;
  assign err       = err_r;
  assign awvalid   = awvalid_r;
  assign arvalid   = arvalid_r;
  assign awaddr    = addr_r;
  assign araddr    = addr_r;
  assign awlen     = W_BLEN'(beats_r - ONE);
  assign arlen     = W_BLEN'(beats_r - ONE);
  assign bready    = bready_r;
  assign wvalid    = (state_r == ST_WDATA) && wr_valid;
  assign wr_ready  = (state_r == ST_WDATA) && wready;
  assign wdata     = wr_data;
  assign wlast     = (state_r == ST_WDATA) && last_beat_s;
  assign rd_valid  = (state_r == ST_RDATA) && rvalid;
  assign rready    = (state_r == ST_RDATA) && rd_ready;
  assign rd_data   = rdata;

endmodule

// File: tb/tb_dmac_iochannel_burst_sequencer.sv
// Randomized bench for the burst sequencer: a bus/stream BFM with random stalls,
// checked against a burst-split model computed from plain arithmetic.
module tb_dmac_iochannel_burst_sequencer;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write, done, err;
  logic [31:0] cmd_addr, cmd_size;
  logic [31:0] wr_data, rd_data, wdata, rdata, awaddr, araddr;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [7:0]  awlen, arlen;

  int unsigned n_cmp = 0, n_bad = 0;

  logic [31:0] src_q[$], wbus_q[$], rsent_q[$], rrecv_q[$], rpend_q[$];
  logic        wlast_q[$];
  logic [31:0] aw_addr_q[$], ar_addr_q[$], exp_addr_q[$];
  int          aw_len_q[$], ar_len_q[$], exp_len_q[$];
  logic        exp_last_q[$];
  int          b_pend, r_idx, r_len;
  int unsigned done_cnt;
  bit          b_hs, r_hs, bad_rlast, addr_valid_seen;

  always #5 ACLK = ~ACLK;

  dmac_iochannel_burst_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .done(done), .err(err),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  // Bus slave and stream endpoints: drive on negedge, observe 1 ns before posedge.
  initial begin
    {awready, arready, wready, bvalid, rvalid, rlast, wr_valid, rd_ready} = 8'h00;
    wr_data = 32'h0; rdata = 32'h0;
    b_pend = 0; r_idx = 0; r_len = 0; done_cnt = 0;
    b_hs = 1'b0; r_hs = 1'b0; bad_rlast = 1'b0; addr_valid_seen = 1'b0;
    forever begin
      @(negedge ACLK);
      if (b_hs) begin bvalid = 1'b0; b_pend--; b_hs = 1'b0; end
      if (r_hs) begin rvalid = 1'b0; void'(rpend_q.pop_front()); r_idx++; r_hs = 1'b0; end
      awready  = ($urandom_range(0, 3) != 0);
      arready  = ($urandom_range(0, 3) != 0);
      wready   = ($urandom_range(0, 3) != 0);
      rd_ready = ($urandom_range(0, 3) != 0);
      wr_valid = (src_q.size() > 0) && ($urandom_range(0, 1) == 1);
      wr_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      if (!bvalid && b_pend > 0 && $urandom_range(0, 2) == 0) bvalid = 1'b1;
      if (!rvalid && rpend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        rvalid = 1'b1;
        rdata  = rpend_q[0];
        rlast  = bad_rlast ? (r_idx == 1) : (r_idx == r_len);
      end
      #4;
      if (done) done_cnt++;
      if (awvalid || arvalid) addr_valid_seen = 1'b1;
      if (awvalid && awready) begin aw_addr_q.push_back(awaddr); aw_len_q.push_back(int'(awlen)); end
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen));
        r_len = int'(arlen); r_idx = 0;
        for (int i = 0; i <= int'(arlen); i++) begin
          logic [31:0] v;
          v = $urandom;
          rpend_q.push_back(v); rsent_q.push_back(v);
        end
      end
      if (wvalid && wready) begin
        wbus_q.push_back(wdata); wlast_q.push_back(wlast);
        if (wlast) b_pend++;
      end
      if (wr_valid && wr_ready) void'(src_q.pop_front());
      if (bvalid && bready) b_hs = 1'b1;
      if (rvalid && rready) r_hs = 1'b1;
      if (rd_valid && rd_ready) rrecv_q.push_back(rd_data);
    end
  end

  // Reference split: each burst is the largest piece allowed by words left, 256 beats and the 4KB page.
  function automatic void build_model(input logic [31:0] a, input int unsigned sz);
    int unsigned room, b;
    exp_addr_q.delete(); exp_len_q.delete(); exp_last_q.delete();
    while (sz > 0) begin
      room = (4096 - (a % 4096)) / 4;
      b = sz;
      if (b > 256) b = 256;
      if (b > room) b = room;
      exp_addr_q.push_back(a); exp_len_q.push_back(int'(b) - 1);
      for (int k = 0; k < int'(b); k++) exp_last_q.push_back(k == int'(b) - 1);
      a  = a + b * 4;
      sz = sz - b;
    end
  endfunction

  task automatic test_reset();
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 32'h0;
    repeat (3) @(negedge ACLK);
    #2;
    n_cmp++;
    if ({cmd_ready, awvalid, arvalid, wvalid, bready, done, err, wr_ready, rready} !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {cmd_ready, awvalid, arvalid, wvalid, bready, done, err, wr_ready, rready});
    end
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK); #2;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_transfer(input bit wr, input logic [31:0] a, input int unsigned sz,
                               input bit bad, input bit exp_err, input string name);
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    int          got_len[$];
    int unsigned d0;
    int          first_bad;
    bit          accepted;
    build_model(a, sz);
    aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    wbus_q.delete(); wlast_q.delete(); rsent_q.delete(); rrecv_q.delete();
    bad_rlast = bad;
    if (wr) for (int i = 0; i < int'(sz); i++) begin
      logic [31:0] v;
      v = $urandom;
      exp_data.push_back(v); src_q.push_back(v);
    end
    d0 = done_cnt;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #4; if (cmd_ready) accepted = 1'b1;
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!accepted) begin n_bad++; $display("FAIL %s_accept: cmd_ready never seen, required 1", name); end
    for (int i = 0; i < int'(sz) * 40 + 200 && done_cnt == d0; i++) @(negedge ACLK);
    n_cmp++;
    if (done_cnt == d0) begin n_bad++; $display("FAIL %s_timeout: no done pulse, required 1", name); end
    repeat (6) @(negedge ACLK);
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL %s_done_count: got %0d required 1", name, done_cnt - d0); end
    if (wr) begin got_addr = aw_addr_q; got_len = aw_len_q; end
    else begin got_addr = ar_addr_q; got_len = ar_len_q; end
    n_cmp++;
    if (got_addr.size() != exp_addr_q.size()) begin
      n_bad++; $display("FAIL %s_burst_count: got %0d required %0d", name, got_addr.size(), exp_addr_q.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr_q.size(); i++) begin
      n_cmp++;
      if (got_addr[i] !== exp_addr_q[i] || got_len[i] != exp_len_q[i]) begin
        n_bad++;
        $display("FAIL %s_burst%0d: got addr %h len %0d required addr %h len %0d",
                 name, i, got_addr[i], got_len[i], exp_addr_q[i], exp_len_q[i]);
      end
    end
    first_bad = -1;
    if (wr) begin
      for (int i = int'(sz) - 1; i >= 0; i--)
        if (i >= wbus_q.size() || wbus_q[i] !== exp_data[i] || wlast_q[i] !== exp_last_q[i]) first_bad = i;
      if (wbus_q.size() != int'(sz)) first_bad = (first_bad < 0) ? int'(sz) : first_bad;
      n_cmp++;
      if (first_bad >= 0) begin
        n_bad++;
        $display("FAIL %s_wdata: %0d beats, first wrong beat %0d, required %0d beats in order with wlast at burst ends",
                 name, wbus_q.size(), first_bad, sz);
      end
    end else begin
      for (int i = int'(sz) - 1; i >= 0; i--)
        if (i >= rrecv_q.size() || i >= rsent_q.size() || rrecv_q[i] !== rsent_q[i]) first_bad = i;
      if (rrecv_q.size() != int'(sz)) first_bad = (first_bad < 0) ? int'(sz) : first_bad;
      n_cmp++;
      if (first_bad >= 0) begin
        n_bad++;
        $display("FAIL %s_rdata: %0d words, first wrong word %0d, required %0d words in bus order",
                 name, rrecv_q.size(), first_bad, sz);
      end
    end
    n_cmp++;
    if (err !== exp_err) begin n_bad++; $display("FAIL %s_err: got %b required %b", name, err, exp_err); end
    bad_rlast = 1'b0;
  endtask

  task automatic test_zero_size();
    bit accepted;
    addr_valid_seen = 1'b0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_size = 32'h0;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      #4; if (cmd_ready) accepted = 1'b1;
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    #4;
    n_cmp++;
    if (done !== 1'b1 || !accepted) begin n_bad++; $display("FAIL zero_done_next: got %b required 1", done); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL zero_err_cleared: got %b required 0", err); end
    @(negedge ACLK); #4;
    n_cmp++;
    if ({done, cmd_ready} !== 2'b01) begin n_bad++; $display("FAIL zero_done_once: done,cmd_ready got %b required 01", {done, cmd_ready}); end
    repeat (4) @(negedge ACLK);
    n_cmp++;
    if (addr_valid_seen) begin n_bad++; $display("FAIL zero_no_addr: address valid seen, required none"); end
  endtask

  task automatic test_reset_midburst();
    int unsigned d0;
    bit seen;
    wbus_q.delete(); wlast_q.delete();
    for (int i = 0; i < 20; i++) src_q.push_back($urandom);
    d0 = done_cnt;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_size = 32'd20;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    for (int i = 0; i < 400 && wbus_q.size() < 4; i++) @(negedge ACLK);
    #1;
    ARESETN = 1'b0;
    src_q.delete(); rpend_q.delete();
    wr_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0; b_pend = 0;
    @(negedge ACLK); #2;
    n_cmp++;
    if ({awvalid, arvalid, wvalid, wlast, bready, done, cmd_ready} !== 7'h00) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b required 0000000",
               {awvalid, arvalid, wvalid, wlast, bready, done, cmd_ready});
    end
    n_cmp++;
    if (wbus_q.size() != 4) begin n_bad++; $display("FAIL midreset_beats: got %0d beats before reset required 4", wbus_q.size()); end
    @(negedge ACLK); ARESETN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin @(negedge ACLK); #2; seen = cmd_ready; end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL midreset_cmd_ready: got 0 required 1"); end
    repeat (5) @(negedge ACLK);
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses required 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_transfer(1'b1, 32'h0000_0FF0, 10, 1'b0, 1'b0, "write_boundary");
    test_transfer(1'b0, 32'h0000_0000, 300, 1'b0, 1'b0, "read_300");
    test_transfer(1'b1, 32'hFFFF_FFF0, 8, 1'b0, 1'b0, "write_wrap");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {16'h0, $urandom_range(0, 16'h3FFF) & 32'h0000_3FFC};
      test_transfer($urandom_range(0, 1) == 1, a, $urandom_range(1, 400), 1'b0, 1'b0, "random");
    end
    test_transfer(1'b0, 32'h0000_0100, 4, 1'b1, 1'b1, "read_rlast_err");
    test_zero_size();
    test_transfer(1'b1, 32'h0000_0FFC, 2, 1'b0, 1'b0, "b2b_write");
    test_transfer(1'b0, 32'h0000_1000, 257, 1'b0, 1'b0, "b2b_read");
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
